uart_trx: RTL and testbench

- Full-duplex 8N1 UART transceiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Transmit path takes parallel bytes via a valid/ready handshake and serialises them on txd.
- Receive path deserialises rxd and emits a one-cycle valid strobe per received byte.
- Used as the core's serial console port and as the bench-side stimulus/monitor model; runs on the 50 MHz core clock.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_trx.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_trx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transceiver: frame constants,
// bit-period derivation helpers and the common FSM state type.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Clock cycles per bit, integer division.
  function automatic int calc_bit_cyc(input int clk_freq, input int baud_ratio);
    return clk_freq / baud_ratio;
  endfunction

  // Clock cycles to the centre of a bit.
  function automatic int calc_half_cyc(input int clk_freq, input int baud_ratio);
    return calc_bit_cyc(clk_freq, baud_ratio) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. A load sets it to one full or one half bit period
// minus one; o_tick is high while the count sits at zero, so the owning FSM
// sees one tick exactly BIT_CYC (or HALF_CYC) cycles after each load.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CYC  = 434,
  parameter int HALF_CYC = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_half,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_half ? HALF_LD : FULL_LD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART transceiver. The TX path serialises bytes accepted on
// a valid/ready handshake; the RX path synchronises rxd, finds the start bit,
// samples at bit centres and strobes rvld for each byte with a good stop bit.
module uart_trx
  import uart_pkg::*;
#(
  parameter int clk_freq   = 50_000_000,
  parameter int baud_ratio = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tdata,
  input  logic       tvld,
  output logic       trdy,
  output logic       txd,
  input  logic       rxd,
  output logic       rvld,
  output logic [7:0] rdata
);

  localparam int BIT_CYC  = calc_bit_cyc(clk_freq, baud_ratio);
  localparam int HALF_CYC = calc_half_cyc(clk_freq, baud_ratio);

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX path
  uart_state_e r_tx_state;
  uart_state_e w_tx_nxt;
  logic [7:0]  r_tx_sh;
  logic [2:0]  r_tx_bit;
  logic        r_txd;
  logic        w_txd_nxt;
  logic        w_tx_load;
  logic        w_tx_tick;
  logic        w_tx_accept;
  logic        w_tx_shift;
  logic        w_tx_bit_inc;
  logic        w_tx_bit_clr;

  uart_bit_timer #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_tx_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tx_load),
    .i_half (1'b0),
    .o_tick (w_tx_tick)
  );

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= IDLE;
    else     r_tx_state <= w_tx_nxt;
  end

  // TX next-state and datapath controls; txd is registered from w_txd_nxt.
  // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_tx_nxt     = r_tx_state;
    w_txd_nxt    = r_txd;
    w_tx_load    = 1'b0;
    w_tx_accept  = 1'b0;
    w_tx_shift   = 1'b0;
    w_tx_bit_inc = 1'b0;
    w_tx_bit_clr = 1'b0;
    case (r_tx_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (tvld) begin
          w_tx_nxt    = START;
          w_tx_load   = 1'b1;
          w_tx_accept = 1'b1;
          w_txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_tx_tick) begin
          w_tx_nxt  = DATA;
          w_tx_load = 1'b1;
          w_txd_nxt = r_tx_sh[0];
        end
      end
      DATA: begin
        if (w_tx_tick) begin
          w_tx_load = 1'b1;
          if (r_tx_bit == BIT_LAST) begin
            w_tx_nxt     = STOP;
            w_tx_bit_clr = 1'b1;
            w_txd_nxt    = 1'b1;
          end else begin
            w_tx_shift   = 1'b1;
            w_tx_bit_inc = 1'b1;
            w_txd_nxt    = r_tx_sh[1];
          end
        end
      end
      STOP: begin
        w_txd_nxt = 1'b1;
        if (w_tx_tick) begin
          if (r_tx_bit == STOP_LAST) begin
            w_tx_nxt = IDLE;
          end else begin
            w_tx_load    = 1'b1;
            w_tx_bit_inc = 1'b1;
          end
        end
      end
      default: begin
        w_tx_nxt  = IDLE;
        w_txd_nxt = 1'b1;
      end
    endcase
  end

  // TX shift register, bit counter and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sh  <= '0;
      r_tx_bit <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_txd <= w_txd_nxt;
      if (w_tx_accept) r_tx_sh <= tdata;
      else if (w_tx_shift) r_tx_sh <= {1'b0, r_tx_sh[7:1]};
      if (w_tx_accept || w_tx_bit_clr) r_tx_bit <= '0;
      else if (w_tx_bit_inc) r_tx_bit <= r_tx_bit + 1'b1;
    end
  end

  assign trdy = (r_tx_state == IDLE);
  assign txd  = r_txd;

  // ---------------------------------------------------------------- RX path
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_d;
  logic        w_rx_fall;
  uart_state_e r_rx_state;
  uart_state_e w_rx_nxt;
  logic [7:0]  r_rx_sh;
  logic [2:0]  r_rx_bit;
  logic        w_rx_load;
  logic        w_rx_half;
  logic        w_rx_tick;
  logic        w_rx_sample;
  logic        w_rx_bit_clr;
  logic        w_rx_done;
  logic        r_rvld;
  logic [7:0]  r_rdata;

  uart_bit_timer #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_rx_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_rx_load),
    .i_half (w_rx_half),
    .o_tick (w_rx_tick)
  );

  // Two-flop synchroniser for the asynchronous rxd, plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  // A line held low after a framing error produces no new falling edge, so
  // IDLE only re-arms once the line has returned high.
  assign w_rx_fall = r_rx_d & ~r_rx_s2;

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= IDLE;
    else     r_rx_state <= w_rx_nxt;
  end

  // RX next-state: half-bit start check, eight centre samples, stop-bit check.
  always_comb begin
    w_rx_nxt     = r_rx_state;
    w_rx_load    = 1'b0;
    w_rx_half    = 1'b0;
    w_rx_sample  = 1'b0;
    w_rx_bit_clr = 1'b0;
    w_rx_done    = 1'b0;
    case (r_rx_state)
      IDLE: begin
        if (w_rx_fall) begin
          w_rx_nxt  = START;
          w_rx_load = 1'b1;
          w_rx_half = 1'b1;
        end
      end
      START: begin
        if (w_rx_tick) begin
          if (!r_rx_s2) begin
            w_rx_nxt     = DATA;
            w_rx_load    = 1'b1;
            w_rx_bit_clr = 1'b1;
          end else begin
            w_rx_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_rx_tick) begin
          w_rx_load   = 1'b1;
          w_rx_sample = 1'b1;
          if (r_rx_bit == BIT_LAST) w_rx_nxt = STOP;
        end
      end
      STOP: begin
        if (w_rx_tick) begin
          w_rx_nxt  = IDLE;
          w_rx_done = r_rx_s2;
        end
      end
      default: w_rx_nxt = IDLE;
    endcase
  end

  // RX shift register, bit counter, output byte and one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sh  <= '0;
      r_rx_bit <= '0;
      r_rvld   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvld <= w_rx_done;
      if (w_rx_done) r_rdata <= r_rx_sh;
      if (w_rx_bit_clr) begin
        r_rx_bit <= '0;
      end else if (w_rx_sample) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 1'b1;
      end
    end
  end

  assign rvld  = r_rvld;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx at default parameters (434 cycles per bit).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_trx;

  localparam int BC = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tvld;
  logic       trdy;
  logic       txd;
  logic       rxd;
  logic       rxd_drv;
  logic       loop_en;
  logic       rvld;
  logic [7:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  int         wide_cnt  = 0;
  logic       prev_rvld = 1'b0;

  logic s_txd  [4400];
  logic s_trdy [4400];

  always #10 clk = ~clk;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_trx dut (
    .clk   (clk),
    .rst   (rst),
    .tdata (tdata),
    .tvld  (tvld),
    .trdy  (trdy),
    .txd   (txd),
    .rxd   (rxd),
    .rvld  (rvld),
    .rdata (rdata)
  );

  // Collect received bytes and flag any strobe wider than one cycle.
  always @(negedge clk) begin
    if (rvld === 1'b1) rx_q.push_back(rdata);
    if (rvld === 1'b1 && prev_rvld) wide_cnt++;
    prev_rvld = (rvld === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_trdy(input string tag);
    int k = 0;
    while (trdy !== 1'b1 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 6000) check({tag, "_timeout"}, 32'(trdy), 32'd1);
  endtask

  task automatic send_tx(input logic [7:0] b);
    wait_trdy("send_tx");
    tdata = b;
    tvld  = 1'b1;
    @(negedge clk);
    tvld  = 1'b0;
  endtask

  // Drive one frame directly on rxd; a low stop bit is followed by an extra low bit time.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (BC) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (BC) @(negedge clk);
    if (!stop) repeat (BC) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (BC) @(negedge clk);
  endtask

  initial begin
    #2_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] msg [5];
    int         busy;

    rst = 1'b1; tvld = 1'b0; tdata = 8'h00; rxd_drv = 1'b1; loop_en = 1'b0;

    // Reset state on the first edge with rst high.
    @(negedge clk);
    check("reset_txd",   32'(txd),   32'd1);
    check("reset_trdy",  32'(trdy),  32'd1);
    check("reset_rvld",  32'(rvld),  32'd0);
    check("reset_rdata", 32'(rdata), 32'h00);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single TX frame of 8'h68, one-cycle tvld.
    tdata = 8'h68;
    tvld  = 1'b1;
    for (int n = 0; n < 4400; n++) begin
      @(negedge clk);
      s_txd[n]  = txd;
      s_trdy[n] = trdy;
      if (n == 0) tvld = 1'b0;
    end
    frame = {1'b1, 8'h68, 1'b0};
    for (int k = 0; k < 10; k++)
      check($sformatf("tx_bit%0d", k), 32'(s_txd[k*BC + BC/2]), 32'(frame[k]));
    check("tx_bit2_last",  32'(s_txd[1735]), 32'd0);
    check("tx_bit3_first", 32'(s_txd[1736]), 32'd1);
    check("tx_bit7_last",  32'(s_txd[3905]), 32'd0);
    check("tx_stop_first", 32'(s_txd[3906]), 32'd1);
    busy = 0;
    for (int n = 0; n < 4400; n++) if (s_trdy[n] == 1'b0) busy++;
    check("tx_busy_cycles", 32'(busy), 32'd4340);
    check("tx_trdy_last_busy", 32'(s_trdy[4339]), 32'd0);
    check("tx_trdy_back",      32'(s_trdy[4340]), 32'd1);
    check("tx_idle_high",      32'(s_txd[4340]),  32'd1);

    // Loopback of "help\n".
    loop_en = 1'b1;
    rx_q.delete();
    wide_cnt = 0;
    msg = '{8'h68, 8'h65, 8'h6C, 8'h70, 8'h0A};
    for (int i = 0; i < 5; i++) send_tx(msg[i]);
    repeat (4500) @(negedge clk);
    check("loop_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("loop_byte%0d", i),
            (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(msg[i]));
    check("loop_rvld_width", 32'(wide_cnt), 32'd0);

    // tvld held high across a frame; tdata changes mid-frame must not be taken early.
    rx_q.delete();
    tdata = 8'hA5;
    tvld  = 1'b1;
    for (int n = 0; n < 4400; n++) begin
      @(negedge clk);
      s_txd[n]  = txd;
      s_trdy[n] = trdy;
      if (n == 10)   tdata = 8'h3C;
      if (n == 4341) tvld  = 1'b0;
    end
    busy = 0;
    for (int n = 0; n < 4341; n++) if (s_trdy[n] == 1'b0) busy++;
    check("b2b_busy_cycles", 32'(busy), 32'd4340);
    check("b2b_trdy_gap",    32'(s_trdy[4340]), 32'd1);
    check("b2b_restart",     32'(s_trdy[4341]), 32'd0);
    check("b2b_start_bit",   32'(s_txd[4341]),  32'd0);
    wait_trdy("b2b");
    repeat (10) @(negedge clk);
    check("b2b_count", 32'(rx_q.size()), 32'd2);
    check("b2b_byte0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'hA5);
    check("b2b_byte1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hDEAD, 32'h3C);

    // Short low glitch, then a frame with a low stop bit, then a good frame.
    loop_en = 1'b0;
    rx_q.delete();
    rxd_drv = 1'b0;
    repeat (100) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_no_rvld", 32'(rx_q.size()), 32'd0);
    check("glitch_rdata",   32'(rdata),       32'h3C);
    send_rx(8'h5A, 1'b0);
    repeat (10) @(negedge clk);
    check("framing_no_rvld", 32'(rx_q.size()), 32'd0);
    check("framing_rdata",   32'(rdata),       32'h3C);
    send_rx(8'h96, 1'b1);
    check("rearm_count", 32'(rx_q.size()), 32'd1);
    check("rearm_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h96);
    check("rearm_rdata", 32'(rdata), 32'h96);

    // Reset 2000 cycles into a TX frame, then a fresh byte looped back.
    rx_q.delete();
    tdata = 8'h81;
    tvld  = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (n == 0) tvld = 1'b0;
    end
    check("mid_frame_txd", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_txd",   32'(txd),   32'd1);
    check("rst_mid_trdy",  32'(trdy),  32'd1);
    check("rst_mid_rvld",  32'(rvld),  32'd0);
    check("rst_mid_rdata", 32'(rdata), 32'h00);
    rst     = 1'b0;
    loop_en = 1'b1;
    tdata   = 8'h42;
    tvld    = 1'b1;
    @(negedge clk);
    tvld = 1'b0;
    check("post_rst_accept", 32'(trdy), 32'd0);
    check("post_rst_start",  32'(txd),  32'd0);
    wait_trdy("post_rst");
    repeat (10) @(negedge clk);
    check("post_rst_count", 32'(rx_q.size()), 32'd1);
    check("post_rst_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
